// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 memory stage: instruction codes and the
// handshake FSM state type.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } mem_state_e;

endpackage

// File: rtl/y86_dmem_array.sv
// Byte-addressed little-endian data memory: one unaligned word-wide
// combinational read port and one synchronous write port. Not reset.
module y86_dmem_array #(
   parameter int DATA_W      = 64,
   parameter int DEPTH_BYTES = 1024,
   parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int WORD_B = DATA_W / 8;

   logic [7:0] mem_q [DEPTH_BYTES];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < WORD_B; i++) begin
            mem_q[addr + ADDR_W'(i)] <= wdata[8*i +: 8];
         end
      end
   end

   // Index arithmetic wraps modulo the array size; callers only use
   // in-range results, so the wrapped bytes never reach a result.
   for (genvar g = 0; g < WORD_B; g++) begin : g_rd
      assign rdata[8*g +: 8] = mem_q[addr + ADDR_W'(g)];
   end

endmodule

// File: rtl/y86_mem_stage.sv
// Y86-64 memory stage: icode decode, range check, wait counter and a
// valid/ready handshake FSM around the data memory array.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | in_ready=1, waiting for a request
// ST_ACCESS | memory op in flight, wait counter running down to commit
// ST_DONE   | out_valid=1, result held until out_ready
module y86_mem_stage
   import y86_pkg::*;
#(
   parameter int DATA_W      = 64,
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        icode,
   input  logic [DATA_W-1:0] valE,
   input  logic [DATA_W-1:0] valA,
   input  logic [DATA_W-1:0] valP,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] valM,
   output logic              dmem_error
);

   localparam int WORD_B = DATA_W / 8;
   localparam int AW     = $clog2(DEPTH_BYTES);
   localparam int CNT_W  = 3;
   localparam logic [DATA_W-1:0] MAX_ADDR = DATA_W'(DEPTH_BYTES - WORD_B);
   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              is_wr_q, is_wr_d;
   logic              is_rd_q, is_rd_d;
   logic              in_range_q, in_range_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] valm_q, valm_d;
   logic              err_q, err_d;

   logic              dec_wr, dec_rd, dec_in_range;
   logic [DATA_W-1:0] dec_addr, dec_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   always_comb begin
      dec_wr    = 1'b0;
      dec_rd    = 1'b0;
      dec_addr  = valE;
      dec_wdata = valA;
      case (icode)
         IRMMOVQ, IPUSHQ: dec_wr = 1'b1;
         ICALL: begin
            dec_wr    = 1'b1;
            dec_wdata = valP;
         end
         IMRMOVQ: dec_rd = 1'b1;
         IPOPQ, IRET: begin
            dec_rd   = 1'b1;
            dec_addr = valA;
         end
         default: ;
      endcase
   end

   // Full-width compare against a constant limit; no addition, so no overflow.
   assign dec_in_range = (dec_addr <= MAX_ADDR);

   assign mem_we = (state_q == ST_ACCESS) && (cnt_q == '0) && is_wr_q && in_range_q;

   y86_dmem_array #(
      .DATA_W      (DATA_W),
      .DEPTH_BYTES (DEPTH_BYTES),
      .ADDR_W      (AW)
   ) u_dmem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_wr_d    = is_wr_q;
      is_rd_d    = is_rd_q;
      in_range_d = in_range_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      valm_d     = valm_q;
      err_d      = err_q;
      in_ready   = (state_q == ST_IDLE);
      out_valid  = (state_q == ST_DONE);
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               is_wr_d    = dec_wr;
               is_rd_d    = dec_rd;
               in_range_d = dec_in_range;
               addr_d     = dec_addr[AW-1:0];
               wdata_d    = dec_wdata;
               cnt_d      = CNT_INIT;
               valm_d     = '0;
               err_d      = 1'b0;
               state_d    = (dec_wr || dec_rd) ? ST_ACCESS : ST_DONE;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               err_d   = !in_range_q;
               valm_d  = (is_rd_q && in_range_q) ? mem_rdata : '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         is_wr_q    <= 1'b0;
         is_rd_q    <= 1'b0;
         in_range_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         valm_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_wr_q    <= is_wr_d;
         is_rd_q    <= is_rd_d;
         in_range_q <= in_range_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         valm_q     <= valm_d;
         err_q      <= err_d;
      end
   end

   assign valM       = valm_q;
   assign dmem_error = err_q;

endmodule

// File: tb/tb_y86_mem_stage.sv
// Self-checking bench for y86_mem_stage: two instances (LATENCY 1 and 4)
// compared against a byte-array reference model of the data memory.
module tb_y86_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iv1 = 1'b0, iv4 = 1'b0;
   logic        ir1, ir4, ov1, ov4, er1, er4;
   logic [63:0] vm1, vm4;
   logic [3:0]  icode_i = 4'h0;
   logic [63:0] vale = '0, vala = '0, valp = '0;
   logic        ordy = 1'b1;

   int total = 0;
   int bad   = 0;

   logic [7:0] mm [2][1024];

   always #5 clk = ~clk;

   y86_mem_stage #(.DATA_W(64), .DEPTH_BYTES(1024), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .icode(icode_i),
      .valE(vale), .valA(vala), .valP(valp), .out_valid(ov1), .out_ready(ordy),
      .valM(vm1), .dmem_error(er1));

   y86_mem_stage #(.DATA_W(64), .DEPTH_BYTES(1024), .LATENCY(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .icode(icode_i),
      .valE(vale), .valA(vala), .valP(valp), .out_valid(ov4), .out_ready(ordy),
      .valM(vm4), .dmem_error(er4));

   // Reference: decode by icode, range rule addr <= 1024-8, little-endian bytes.
   function automatic void model(input int s, input logic [3:0] ic,
                                 input logic [63:0] e, input logic [63:0] a,
                                 input logic [63:0] p, output logic [63:0] vm,
                                 output logic er, output int lat);
      logic [63:0] addr, wd;
      bit wr, rd;
      int ia;
      wr = 0; rd = 0; addr = e; wd = a;
      case (ic)
         4'h4, 4'hA: wr = 1;
         4'h8: begin wr = 1; wd = p; end
         4'h5: rd = 1;
         4'h9, 4'hB: begin rd = 1; addr = a; end
         default: ;
      endcase
      vm = '0; er = 1'b0;
      lat = (wr || rd) ? ((s == 0) ? 1 : 4) : 0;
      if (wr || rd) begin
         if (addr > 64'd1016) er = 1'b1;
         else begin
            ia = int'(addr);
            for (int i = 0; i < 8; i++) begin
               if (wr) mm[s][ia+i] = wd[8*i +: 8];
               else vm[8*i +: 8] = mm[s][ia+i];
            end
         end
      end
   endfunction

   // Drive one request into instance s with out_ready=1; return result and
   // the number of edges between the accepting edge and out_valid.
   task automatic run_txn(input int s, input logic [3:0] ic, input logic [63:0] e,
                          input logic [63:0] a, input logic [63:0] p,
                          output logic [63:0] vm, output logic er, output int lat);
      int n;
      icode_i = ic; vale = e; vala = a; valp = p; ordy = 1'b1;
      if (s == 0) iv1 = 1'b1; else iv4 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0; iv4 = 1'b0;
      n = 0;
      while (((s == 0) ? ov1 : ov4) !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n >= 50) begin
         bad++;
         $display("FAIL txn_timeout inst=%0d icode=%h got_cycles=%0d need<50", s, ic, n);
      end
      lat = n;
      vm  = (s == 0) ? vm1 : vm4;
      er  = (s == 0) ? er1 : er4;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({ov1, ov4, er1, er4} !== 4'b0000 || vm1 !== 64'd0 || vm4 !== 64'd0) begin
         bad++;
         $display("FAIL reset_outputs got ov=%b%b er=%b%b vm1=%h vm4=%h exp all 0",
                  ov1, ov4, er1, er4, vm1, vm4);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({ir1, ir4} !== 2'b11) begin
         bad++;
         $display("FAIL reset_in_ready got=%b%b exp=11", ir1, ir4);
      end
   endtask

   task automatic init_mem;
      logic [63:0] vm, evm; logic er, eer; int lat, elat;
      for (int s = 0; s < 2; s++) begin
         for (int ad = 0; ad < 1024; ad += 8) begin
            model(s, 4'h4, 64'(ad), 64'd0, 64'd0, evm, eer, elat);
            run_txn(s, 4'h4, 64'(ad), 64'd0, 64'd0, vm, er, lat);
         end
      end
   endtask

   task automatic test_store_load;
      logic [63:0] vm, evm; logic er, eer; int lat, elat;
      model(0, 4'h4, 64'd8, 64'h1122334455667788, 0, evm, eer, elat);
      run_txn(0, 4'h4, 64'd8, 64'h1122334455667788, 0, vm, er, lat);
      total++;
      if (er !== 1'b0 || lat !== 1) begin
         bad++;
         $display("FAIL store_err_lat got er=%b lat=%0d exp er=0 lat=1", er, lat);
      end
      run_txn(0, 4'h5, 64'd8, 0, 0, vm, er, lat);
      total++;
      if (vm !== 64'h1122334455667788 || er !== 1'b0 || lat !== 1) begin
         bad++;
         $display("FAIL load_8 got vm=%h er=%b lat=%0d exp vm=1122334455667788 er=0 lat=1",
                  vm, er, lat);
      end
      total++;
      if (vm[7:0] !== 8'h88) begin
         bad++;
         $display("FAIL byte8 got=%h exp=88", vm[7:0]);
      end
      run_txn(0, 4'h5, 64'd1, 0, 0, vm, er, lat);
      total++;
      if (vm !== 64'h8800000000000000 || er !== 1'b0) begin
         bad++;
         $display("FAIL unaligned_1 got vm=%h er=%b exp vm=8800000000000000 er=0", vm, er);
      end
   endtask

   task automatic test_push_pop;
      logic [63:0] vm, evm; logic er, eer; int lat, elat;
      model(0, 4'hA, 64'h3F8, 64'd4, 0, evm, eer, elat);
      run_txn(0, 4'hA, 64'h3F8, 64'd4, 0, vm, er, lat);
      run_txn(0, 4'hB, 0, 64'h3F8, 0, vm, er, lat);
      total++;
      if (vm !== 64'd4 || er !== 1'b0) begin
         bad++;
         $display("FAIL popq got vm=%h er=%b exp vm=4 er=0", vm, er);
      end
      model(0, 4'h8, 64'h3F0, 64'h123, 64'h40, evm, eer, elat);
      run_txn(0, 4'h8, 64'h3F0, 64'h123, 64'h40, vm, er, lat);
      run_txn(0, 4'h9, 64'h777, 64'h3F0, 0, vm, er, lat);
      total++;
      if (vm !== 64'h40 || er !== 1'b0) begin
         bad++;
         $display("FAIL ret got vm=%h er=%b exp vm=40 er=0", vm, er);
      end
   endtask

   task automatic test_boundary;
      logic [63:0] vm; logic er; int lat;
      run_txn(0, 4'h5, 64'd1016, 0, 0, vm, er, lat);
      total++;
      if (er !== 1'b0) begin
         bad++;
         $display("FAIL bound_1016 got er=%b exp=0", er);
      end
      run_txn(0, 4'h5, 64'd1017, 0, 0, vm, er, lat);
      total++;
      if (er !== 1'b1 || vm !== 64'd0) begin
         bad++;
         $display("FAIL bound_1017 got er=%b vm=%h exp er=1 vm=0", er, vm);
      end
      run_txn(0, 4'h4, 64'hFFFFFFFFFFFFFFFC, 64'hDEADBEEFCAFEF00D, 0, vm, er, lat);
      total++;
      if (er !== 1'b1 || vm !== 64'd0) begin
         bad++;
         $display("FAIL wr_top got er=%b vm=%h exp er=1 vm=0", er, vm);
      end
      run_txn(0, 4'h5, 64'h3F8, 0, 0, vm, er, lat);
      total++;
      if (vm !== 64'd4 || er !== 1'b0) begin
         bad++;
         $display("FAIL after_bad_wr got vm=%h er=%b exp vm=4 er=0", vm, er);
      end
   endtask

   task automatic test_no_access;
      logic [63:0] vm; logic er; int lat;
      logic [3:0] codes [3];
      codes[0] = 4'h6; codes[1] = 4'h0; codes[2] = 4'h7;
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 3; k++) begin
            run_txn(s, codes[k], 64'd8, 64'd16, 64'd24, vm, er, lat);
            total++;
            if (vm !== 64'd0 || er !== 1'b0 || lat !== 0) begin
               bad++;
               $display("FAIL no_access inst=%0d icode=%h got vm=%h er=%b lat=%0d exp 0/0/0",
                        s, codes[k], vm, er, lat);
            end
         end
      end
   endtask

   task automatic test_latency_stall;
      logic [63:0] vm, evm, snap; logic er, eer; int lat, elat, n;
      model(1, 4'h4, 64'h200, 64'hA5A5_0102_0304_5A5A, 0, evm, eer, elat);
      run_txn(1, 4'h4, 64'h200, 64'hA5A5_0102_0304_5A5A, 0, vm, er, lat);
      icode_i = 4'h5; vale = 64'h200; ordy = 1'b0; iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      n = 0;
      while (ov4 !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n !== 4) begin
         bad++;
         $display("FAIL lat4 got=%0d exp=4", n);
      end
      snap = vm4;
      total++;
      if (snap !== 64'hA5A5_0102_0304_5A5A) begin
         bad++;
         $display("FAIL lat4_data got=%h exp=a5a501020304 5a5a", snap);
      end
      // A request presented during the stall must be ignored.
      icode_i = 4'h4; vala = 64'h1111; iv4 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         total++;
         if (ov4 !== 1'b1 || ir4 !== 1'b0 || vm4 !== snap || er4 !== 1'b0) begin
            bad++;
            $display("FAIL stall c=%0d got ov=%b ir=%b vm=%h er=%b exp ov=1 ir=0 vm=%h er=0",
                     c, ov4, ir4, vm4, er4, snap);
         end
      end
      ordy = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      total++;
      if (ir4 !== 1'b1 || ov4 !== 1'b0) begin
         bad++;
         $display("FAIL stall_release got ir=%b ov=%b exp ir=1 ov=0", ir4, ov4);
      end
      run_txn(1, 4'h5, 64'h200, 0, 0, vm, er, lat);
      total++;
      if (vm !== 64'hA5A5_0102_0304_5A5A) begin
         bad++;
         $display("FAIL ignored_req got=%h exp=a5a5010203045a5a", vm);
      end
   endtask

   task automatic test_reset_mid;
      logic [63:0] vm, evm; logic er, eer; int lat, elat;
      model(1, 4'h4, 64'h100, 64'h0BAD_F00D_0000_0001, 0, evm, eer, elat);
      run_txn(1, 4'h4, 64'h100, 64'h0BAD_F00D_0000_0001, 0, vm, er, lat);
      icode_i = 4'h4; vale = 64'h100; vala = 64'hFFFF_EEEE_DDDD_CCCC; iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (ov4 !== 1'b0 || vm4 !== 64'd0 || er4 !== 1'b0 || ir4 !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid got ov=%b vm=%h er=%b ir=%b exp ov=0 vm=0 er=0 ir=1",
                  ov4, vm4, er4, ir4);
      end
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_txn(1, 4'h5, 64'h100, 0, 0, vm, er, lat);
      total++;
      if (vm !== 64'h0BAD_F00D_0000_0001 || er !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_old got vm=%h er=%b exp vm=0badf00d00000001 er=0", vm, er);
      end
   endtask

   task automatic test_back_to_back;
      logic [63:0] evm; logic eer; int elat;
      int acc [4];
      int k, c, n;
      model(0, 4'h5, 64'd8, 0, 0, evm, eer, elat);
      icode_i = 4'h5; vale = 64'd8; ordy = 1'b1; iv1 = 1'b1;
      k = 0; c = 0;
      while (k < 4 && c < 40) begin
         if (ov1 === 1'b1) begin
            total++;
            if (vm1 !== evm) begin
               bad++;
               $display("FAIL b2b_data got=%h exp=%h", vm1, evm);
            end
         end
         if (ir1 === 1'b1) begin
            acc[k] = c;
            k++;
         end
         @(posedge clk); #1;
         c++;
      end
      iv1 = 1'b0;
      total++;
      if (k !== 4 || acc[1] - acc[0] !== 3 || acc[3] - acc[0] !== 9) begin
         bad++;
         $display("FAIL b2b_rate got accepts=%0d span1=%0d span3=%0d exp 4/3/9",
                  k, acc[1] - acc[0], acc[3] - acc[0]);
      end
      n = 0;
      while (ir1 !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n >= 20) begin
         bad++;
         $display("FAIL b2b_drain got_cycles=%0d need<20", n);
      end
   endtask

   task automatic test_random;
      logic [63:0] vm, evm, e, a, p; logic er, eer; int lat, elat, s;
      logic [3:0] ic;
      logic [3:0] ics [10];
      ics[0] = 4'h4; ics[1] = 4'h5; ics[2] = 4'h8; ics[3] = 4'h9; ics[4] = 4'hA;
      ics[5] = 4'hB; ics[6] = 4'h5; ics[7] = 4'h1; ics[8] = 4'h6; ics[9] = 4'hC;
      for (int t = 0; t < 80; t++) begin
         s  = int'($urandom_range(0, 1));
         ic = ics[$urandom_range(0, 9)];
         for (int j = 0; j < 2; j++) begin
            int r;
            logic [63:0] ad;
            r = int'($urandom_range(0, 9));
            if (r == 0) ad = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
            else if (r == 1) ad = 64'($urandom_range(1009, 1023));
            else ad = 64'($urandom_range(0, 1016));
            if (j == 0) e = ad; else a = ad;
         end
         if ($urandom_range(0, 1) == 1) begin
            // Turn the non-address operand into data for stores.
            if (ic == 4'h4 || ic == 4'hA) a = {$urandom, $urandom};
         end
         p = {$urandom, $urandom};
         model(s, ic, e, a, p, evm, eer, elat);
         run_txn(s, ic, e, a, p, vm, er, lat);
         total++;
         if (vm !== evm || er !== eer || lat !== elat) begin
            bad++;
            $display("FAIL random t=%0d inst=%0d icode=%h got vm=%h er=%b lat=%0d exp vm=%h er=%b lat=%0d",
                     t, s, ic, vm, er, lat, evm, eer, elat);
         end
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++)
         for (int b = 0; b < 1024; b++) mm[s][b] = 8'h00;
      test_reset;
      init_mem;
      test_store_load;
      test_push_pop;
      test_boundary;
      test_no_access;
      test_latency_stall;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
